// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pattern pipeline: screen size, mode codes, box direction, colours.
// Pure declarations, no logic.
// No handshake involved.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [2:0] MODE_BLACK   = 3'd0;
  localparam logic [2:0] MODE_WHITE   = 3'd1;
  localparam logic [2:0] MODE_BARS    = 3'd2;
  localparam logic [2:0] MODE_CHECKER = 3'd3;
  localparam logic [2:0] MODE_HGRAD   = 3'd4;
  localparam logic [2:0] MODE_VGRAD   = 3'd5;
  localparam logic [2:0] MODE_BOX     = 3'd6;
  localparam logic [2:0] MODE_CYCLE   = 3'd7;

  // Bit 1 selects LEFT on x, bit 0 selects UP on y.
  typedef enum logic [1:0] {
    RIGHT_DOWN = 2'b00,
    RIGHT_UP   = 2'b01,
    LEFT_DOWN  = 2'b10,
    LEFT_UP    = 2'b11
  } dir_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = 24'h000000;
  localparam rgb_t RGB_WHITE = 24'hFFFFFF;
  localparam rgb_t RGB_RED   = 24'hFF0000;
  localparam logic [7:0] BOX_BG_B = 8'h80;

  function automatic logic [7:0] expand_bit(input logic b);
    return {8{b}};
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Per-frame animation state: bouncing-box position, direction per axis, and an 8-bit frame counter.
// Updates one clock after a qualified step pulse.
// No backpressure; step is a single-cycle strobe.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int BOX_SIZE = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - BOX_SIZE);

  dir_t dir;
  logic next_left;
  logic next_up;

  // A flip happens on the same step that reaches the limit, so the box never overshoots.
  always_comb begin
    next_left = dir[1] ? (box_x != 10'd0) : (box_x == X_MAX);
    next_up   = dir[0] ? (box_y != 10'd0) : (box_y == Y_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      box_x     <= 10'd0;
      box_y     <= 10'd0;
      dir       <= RIGHT_DOWN;
      frame_cnt <= 8'd0;
    end else if (step) begin
      box_x     <= next_left ? box_x - 10'd1 : box_x + 10'd1;
      box_y     <= next_up   ? box_y - 10'd1 : box_y + 10'd1;
      dir       <= dir_t'({next_left, next_up});
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source driving the VGA pins; optional red border under PATTERN_BORDER_EN.
// Latency: 2 pix_en strobes from coordinates/sync/active to RGB, sync and blank.
// No backpressure; every register holds while pix_en is low.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int BOX_SIZE = 32,
  parameter int BAR_W    = 80
) (
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic       pix_en,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       active_in,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       frame_start,
  input  logic [2:0] SW,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N
);

  logic       frame_step;
  logic [2:0] mode;
  logic       started;
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic [7:0] frame_cnt;

  assign frame_step = pix_en & frame_start;

  vga_box_mover #(.BOX_SIZE(BOX_SIZE)) u_box (
    .clk       (CLOCK_50),
    .rst_n     (KEY),
    .step      (frame_step),
    .box_x     (box_x),
    .box_y     (box_y),
    .frame_cnt (frame_cnt)
  );

  // Mode only changes at a frame boundary; output stays blank until the first frame after reset.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      mode    <= MODE_BLACK;
      started <= 1'b0;
    end else if (frame_step) begin
      mode    <= SW;
      started <= 1'b1;
    end
  end

  logic [9:0] bar_idx;
  logic       in_box;
  rgb_t       pat;
  rgb_t       pat_sel;

  assign bar_idx = hcount / 10'(BAR_W);
  assign in_box  = ({1'b0, hcount} >= {1'b0, box_x}) &&
                   ({1'b0, hcount} <  {1'b0, box_x} + 11'(BOX_SIZE)) &&
                   ({1'b0, vcount} >= {1'b0, box_y}) &&
                   ({1'b0, vcount} <  {1'b0, box_y} + 11'(BOX_SIZE));

  always_comb begin
    pat = RGB_BLACK;
    case (mode)
      MODE_BLACK:   pat = RGB_BLACK;
      MODE_WHITE:   pat = RGB_WHITE;
      MODE_BARS:    pat = '{expand_bit(bar_idx[2]), expand_bit(bar_idx[1]), expand_bit(bar_idx[0])};
      MODE_CHECKER: pat = (hcount[5] ^ vcount[5]) ? RGB_WHITE : RGB_BLACK;
      MODE_HGRAD:   pat = '{hcount[9:2], hcount[9:2], hcount[9:2]};
      MODE_VGRAD:   pat = '{vcount[8:1], vcount[8:1], vcount[8:1]};
      MODE_BOX:     pat = in_box ? RGB_WHITE : '{8'h00, 8'h00, BOX_BG_B};
      MODE_CYCLE:   pat = '{frame_cnt, ~frame_cnt, BOX_BG_B};
      default:      pat = RGB_BLACK;
    endcase
  end

`ifdef PATTERN_BORDER_EN
  logic on_border;
  assign on_border = (hcount == 10'd0) || (hcount == 10'(H_ACTIVE - 1)) ||
                     (vcount == 10'd0) || (vcount == 10'(V_ACTIVE - 1));
  always_comb begin
    pat_sel = pat;
    if (on_border) pat_sel = RGB_RED;
  end
`else
  always_comb begin
    pat_sel = pat;
  end
`endif

  rgb_t pat_s1;
  logic act_s1, hs_s1, vs_s1;
  rgb_t rgb_s2;
  logic act_s2, hs_s2, vs_s2;

  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      pat_s1 <= RGB_BLACK;
      act_s1 <= 1'b0;
      hs_s1  <= 1'b1;
      vs_s1  <= 1'b1;
      rgb_s2 <= RGB_BLACK;
      act_s2 <= 1'b0;
      hs_s2  <= 1'b1;
      vs_s2  <= 1'b1;
    end else if (pix_en) begin
      pat_s1 <= pat_sel;
      act_s1 <= active_in & started;
      hs_s1  <= hs_in;
      vs_s1  <= vs_in;
      rgb_s2 <= act_s1 ? pat_s1 : RGB_BLACK;
      act_s2 <= act_s1;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
    end
  end

  assign VGA_R       = rgb_s2.r;
  assign VGA_G       = rgb_s2.g;
  assign VGA_B       = rgb_s2.b;
  assign VGA_HS      = hs_s2;
  assign VGA_VS      = vs_s2;
  assign VGA_BLANK_N = act_s2;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed plus randomized bench for vga_pattern_gen against a frame-level reference model.
// Model tracks frame count, latched mode and a two-strobe output delay line.
module tb_vga_pattern_gen;
  import vga_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       KEY = 1'b0;
  logic       pix_en = 1'b0;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic       active_in = 1'b0;
  logic       hs_in = 1'b1;
  logic       vs_in = 1'b1;
  logic       frame_start = 1'b0;
  logic [2:0] SW = 3'd0;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N;

  vga_pattern_gen dut (
    .CLOCK_50    (CLOCK_50),
    .KEY         (KEY),
    .pix_en      (pix_en),
    .hcount      (hcount),
    .vcount      (vcount),
    .active_in   (active_in),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .frame_start (frame_start),
    .SW          (SW),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  localparam logic [26:0] RST_OUT = {24'h000000, 1'b1, 1'b1, 1'b0};
  localparam int X_LIM = H_ACTIVE - 32;
  localparam int Y_LIM = V_ACTIVE - 32;

  int          n_assert = 0;
  int          n_fail = 0;
  int          n_frames = 0;
  logic [2:0]  m_mode = 3'd0;
  bit          m_started = 1'b0;
  logic [26:0] q1 = RST_OUT;
  logic [26:0] q2 = RST_OUT;

  // Box position as a triangle wave over the frame count.
  function automatic int tri_pos(input int n, input int lim);
    int m;
    m = n % (2 * lim);
    return (m <= lim) ? m : 2 * lim - m;
  endfunction

  function automatic logic [23:0] model_rgb(input int h, input int v, input bit act,
                                            input logic [2:0] md, input int n);
    int bx, by, bar;
    logic [7:0] fc;
    if (!act) return 24'h000000;
`ifdef PATTERN_BORDER_EN
    if (h == 0 || h == H_ACTIVE - 1 || v == 0 || v == V_ACTIVE - 1) return 24'hFF0000;
`endif
    case (md)
      3'd0: return 24'h000000;
      3'd1: return 24'hFFFFFF;
      3'd2: begin
        bar = (h / 80) % 8;
        return {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
      end
      3'd3: return ((((h / 32) + (v / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      3'd4: return {3{8'(h / 4)}};
      3'd5: return {3{8'((v / 2) % 256)}};
      3'd6: begin
        bx = tri_pos(n, X_LIM);
        by = tri_pos(n, Y_LIM);
        return (h >= bx && h < bx + 32 && v >= by && v < by + 32) ? 24'hFFFFFF : 24'h000080;
      end
      default: begin
        fc = 8'(n % 256);
        return {fc, ~fc, 8'h80};
      end
    endcase
  endfunction

  task automatic check_out(input string tag);
    n_assert++;
    assert ({VGA_R, VGA_G, VGA_B} === q2[26:3]) else begin
      n_fail++;
      $error("FAIL %s_rgb: observed %h expected %h", tag, {VGA_R, VGA_G, VGA_B}, q2[26:3]);
    end
    n_assert++;
    assert ({VGA_HS, VGA_VS, VGA_BLANK_N} === q2[2:0]) else begin
      n_fail++;
      $error("FAIL %s_sync: observed hs/vs/blank_n %b expected %b", tag,
             {VGA_HS, VGA_VS, VGA_BLANK_N}, q2[2:0]);
    end
  endtask

  task automatic expect_rgb(input string tag, input logic [23:0] exp);
    n_assert++;
    assert ({VGA_R, VGA_G, VGA_B} === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, {VGA_R, VGA_G, VGA_B}, exp);
    end
  endtask

  task automatic expect_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic strobe(input int h, input int v, input bit act, input bit hs,
                        input bit vs, input bit fs);
    bit act_eff;
    hcount = h[9:0];
    vcount = v[9:0];
    active_in = act;
    hs_in = hs;
    vs_in = vs;
    frame_start = fs;
    pix_en = 1'b1;
    @(posedge CLOCK_50);
    act_eff = act && m_started;
    q2 = q1;
    q1 = {model_rgb(h, v, act_eff, m_mode, n_frames), hs, vs, act_eff};
    if (fs) begin
      n_frames++;
      m_mode = SW;
      m_started = 1'b1;
    end
    #1 check_out("strobe");
    pix_en = 1'b0;
    frame_start = 1'b0;
    @(posedge CLOCK_50);
    #1 check_out("gap");
  endtask

  task automatic rand_pixel();
    strobe($urandom_range(0, H_ACTIVE - 1), $urandom_range(0, V_ACTIVE - 1),
           ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic frame_pulse();
    strobe(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    KEY = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      pix_en = 1'(i % 2);
      hcount = 10'($urandom_range(0, 639));
      active_in = 1'b1;
      @(posedge CLOCK_50);
      n_frames = 0;
      m_mode = 3'd0;
      m_started = 1'b0;
      q1 = RST_OUT;
      q2 = RST_OUT;
      #1 check_out("reset");
    end
    pix_en = 1'b0;
    KEY = 1'b1;
  endtask

  initial begin
    // 1: reset, then no output before the first frame_start
    do_reset(25);
    for (int i = 0; i < 3; i++) strobe(100 + i, 50, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_bit("blank_before_frame", VGA_BLANK_N, 1'b0);

    // 2: colour bars
    SW = 3'b010;
    frame_pulse();
    strobe(85, 10, 1'b1, 1'b1, 1'b1, 1'b0);
    strobe(565, 10, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_rgb("bar1", 24'h0000FF);
    strobe(0, 11, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_rgb("bar7", 24'hFFFFFF);

    // 3: mid-frame mode change only lands at the next frame
    SW = 3'b100;
    frame_pulse();
    strobe(400, 100, 1'b1, 1'b1, 1'b1, 1'b0);
    SW = 3'b110;
    strobe(400, 101, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_rgb("grad_before_change", 24'h646464);
    strobe(400, 102, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_rgb("grad_after_sw", 24'h646464);
    frame_pulse();
    strobe(tri_pos(n_frames, X_LIM) + 1, tri_pos(n_frames, Y_LIM) + 1, 1'b1, 1'b1, 1'b1, 1'b0);
    strobe(300, 300, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_rgb("box_after_frame", 24'hFFFFFF);

    // 4: 700 frames of box motion from reset
    do_reset(3);
    SW = 3'b110;
    for (int f = 1; f <= 700; f++) begin
      frame_pulse();
      rand_pixel();
      if (f == 448 || f == 608) begin
        strobe(tri_pos(f, X_LIM), tri_pos(f, Y_LIM), 1'b1, 1'b1, 1'b1, 1'b0);
        strobe(tri_pos(f, X_LIM) + 31, tri_pos(f, Y_LIM) + 31, 1'b1, 1'b1, 1'b1, 1'b0);
        strobe(tri_pos(f, X_LIM) + 32, tri_pos(f, Y_LIM), 1'b1, 1'b1, 1'b1, 1'b0);
      end
    end
    strobe(516, 196, 1'b1, 1'b1, 1'b1, 1'b0);
    strobe(515, 196, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_rgb("box700_tl", 24'hFFFFFF);
    strobe(547, 227, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_rgb("box700_left_out", 24'h000080);
    strobe(548, 227, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_rgb("box700_br", 24'hFFFFFF);
    strobe(516, 228, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_rgb("box700_right_out", 24'h000080);
    strobe(10, 10, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_rgb("box700_below_out", 24'h000080);

    // 5: pix_en low freezes everything; sync edges land two strobes later
    strobe(200, 20, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      hcount = 10'($urandom_range(0, 639));
      active_in = 1'($urandom_range(0, 1));
      hs_in = 1'($urandom_range(0, 1));
      @(posedge CLOCK_50);
      #1 check_out("hold");
    end
    strobe(201, 20, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_bit("hs_edge_1", VGA_HS, 1'b1);
    strobe(202, 20, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_bit("hs_edge_2", VGA_HS, 1'b0);
    expect_bit("blank_edge_2", VGA_BLANK_N, 1'b0);
    strobe(203, 20, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_bit("blank_edge_3", VGA_BLANK_N, 1'b1);

    // mid-frame reset, then resume at the next frame
    do_reset(1);
    strobe(50, 50, 1'b1, 1'b1, 1'b1, 1'b0);
    strobe(51, 50, 1'b1, 1'b1, 1'b1, 1'b0);
    SW = 3'b001;
    frame_pulse();
    strobe(320, 240, 1'b1, 1'b1, 1'b1, 1'b0);

    // 6: right edge pixel with/without border
    strobe(639, 100, 1'b1, 1'b1, 1'b1, 1'b0);
    strobe(320, 100, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef PATTERN_BORDER_EN
    expect_rgb("edge_639", 24'hFF0000);
`else
    expect_rgb("edge_639", 24'hFFFFFF);
`endif

    // randomized modes and pixels
    for (int f = 0; f < 40; f++) begin
      SW = 3'($urandom_range(0, 7));
      frame_pulse();
      for (int p = 0; p < 8; p++) rand_pixel();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
